// File: rtl/cam_pwr_pkg.sv
// Shared encodings for the camera power supervisor: top FSM states,
// per-rail monitor states, rail indices and a counter-width helper.
package cam_pwr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_BOOT  = 3'd2,
        ST_READY = 3'd3,
        ST_FAULT = 3'd4
    } pwr_state_t;

    typedef enum logic [2:0] {
        RAIL_OFF     = 3'd0,
        RAIL_RAMP    = 3'd1,
        RAIL_GOOD    = 3'd2,
        RAIL_TIMEOUT = 3'd3,
        RAIL_DROP    = 3'd4
    } rail_state_t;

    localparam int RAIL_1V2  = 0;
    localparam int RAIL_1V8  = 1;
    localparam int RAIL_3V3  = 2;
    localparam int NUM_RAILS = 3;

    // Bits needed to hold values 0..max_val, never less than 1.
    function automatic int cnt_width(input longint unsigned max_val);
        int w;
        w = 1;
        while (w < 40 && (longint'(1) << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/cam_rail_pg_monitor.sv
// One regulator rail: PG synchroniser, ramp timeout and drop glitch filter.
// A single saturating counter serves as ramp timer in RAMP and glitch run in GOOD.
module cam_rail_pg_monitor
    import cam_pwr_pkg::*;
#(
    parameter logic [31:0] PG_TIMEOUT    = 32'd100000,
    parameter logic [31:0] GLITCH_CYCLES = 32'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pg,
    output rail_state_t state
);

    localparam logic [31:0] CNT_MAX = (PG_TIMEOUT > GLITCH_CYCLES) ? PG_TIMEOUT : GLITCH_CYCLES;
    localparam int CW = cnt_width(64'(CNT_MAX));
    localparam logic [CW-1:0] TIMEOUT_C = CW'(PG_TIMEOUT);
    localparam logic [CW-1:0] GLITCH_LAST = (GLITCH_CYCLES == 32'd0) ? '0 : CW'(GLITCH_CYCLES - 32'd1);

    logic          pg_meta;
    logic          pg_sync;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    rail_state_t   state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pg_meta <= 1'b0;
            pg_sync <= 1'b0;
        end else begin
            pg_meta <= pg;
            pg_sync <= pg_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RAIL_OFF;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!en) begin
            state_next = RAIL_OFF;
            cnt_next   = '0;
        end else begin
            case (state)
                RAIL_OFF: begin
                    state_next = RAIL_RAMP;
                    cnt_next   = '0;
                end
                RAIL_RAMP: begin
                    if (pg_sync && cnt < TIMEOUT_C) begin
                        state_next = RAIL_GOOD;
                        cnt_next   = '0;
                    end else if (cnt >= TIMEOUT_C) begin
                        state_next = RAIL_TIMEOUT;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                RAIL_GOOD: begin
                    // Any high sample restarts the low-run count.
                    if (pg_sync) begin
                        cnt_next = '0;
                    end else if (cnt >= GLITCH_LAST) begin
                        state_next = RAIL_DROP;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                default: state_next = state;
            endcase
        end
    end

endmodule

// File: rtl/camera_power_supervisor.sv
// Watches rail enables, PG pins, XCLR and INCK_EN and raises cam_ready_o after
// the boot delay. Define CAM_PWR_FAULT_IRQ_EN to add the fault_irq_o pulse output.
module camera_power_supervisor
    import cam_pwr_pkg::*;
#(
    parameter logic [31:0] PG_TIMEOUT    = 32'd100000,
    parameter logic [31:0] GLITCH_CYCLES = 32'd16,
    parameter logic [31:0] BOOT_DELAY    = 32'd500000
) (
    input  logic       ctrl_clk_i,
    input  logic       ctrl_rst_n_i,
    input  logic       reg_1v2_en_i,
    input  logic       reg_1v8_en_i,
    input  logic       reg_3v3_en_i,
    input  logic       xclr_i,
    input  logic       inck_en_i,
    input  logic       pg_1v2_i,
    input  logic       pg_1v8_i,
    input  logic       pg_3v3_i,
    input  logic       fault_clr_i,
    output logic       cam_ready_o,
    output logic       pwr_fault_o,
    output logic [2:0] fault_timeout_o,
    output logic [2:0] fault_drop_o,
    output logic [2:0] state_o
`ifdef CAM_PWR_FAULT_IRQ_EN
    ,
    output logic       fault_irq_o
`endif
);

    localparam int BW = cnt_width(64'(BOOT_DELAY));
    localparam logic [BW-1:0] BOOT_LAST = (BOOT_DELAY == 32'd0) ? '0 : BW'(BOOT_DELAY - 32'd1);

    logic [NUM_RAILS-1:0] en_vec;
    logic [NUM_RAILS-1:0] pg_vec;
    logic [NUM_RAILS-1:0] good_vec;
    logic [NUM_RAILS-1:0] to_vec;
    logic [NUM_RAILS-1:0] drop_vec;
    rail_state_t          rail_st [NUM_RAILS];

    pwr_state_t    state;
    pwr_state_t    state_next;
    logic [BW-1:0] boot_cnt;
    logic [2:0]    flag_to;
    logic [2:0]    flag_drop;
    logic          any_en;
    logic          any_fault;
    logic          chain_ok;

    assign en_vec = {reg_3v3_en_i, reg_1v8_en_i, reg_1v2_en_i};
    assign pg_vec = {pg_3v3_i, pg_1v8_i, pg_1v2_i};

    for (genvar i = 0; i < NUM_RAILS; i++) begin : g_rail
        cam_rail_pg_monitor #(
            .PG_TIMEOUT   (PG_TIMEOUT),
            .GLITCH_CYCLES(GLITCH_CYCLES)
        ) u_mon (
            .clk  (ctrl_clk_i),
            .rst_n(ctrl_rst_n_i),
            .en   (en_vec[i]),
            .pg   (pg_vec[i]),
            .state(rail_st[i])
        );
        assign good_vec[i] = (rail_st[i] == RAIL_GOOD);
        assign to_vec[i]   = (rail_st[i] == RAIL_TIMEOUT);
        assign drop_vec[i] = (rail_st[i] == RAIL_DROP);
    end

    assign any_en    = |en_vec;
    assign any_fault = |(to_vec | drop_vec);
    assign chain_ok  = (&en_vec) && xclr_i && inck_en_i;

    always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
        if (!ctrl_rst_n_i) state <= ST_IDLE;
        else               state <= state_next;
    end

    // Fault outranks clear, teardown and boot completion in every state.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_en) state_next = ST_RAMP;
            ST_RAMP: begin
                if (any_fault)                                state_next = ST_FAULT;
                else if (!any_en)                             state_next = ST_IDLE;
                else if ((&good_vec) && xclr_i && inck_en_i)  state_next = ST_BOOT;
            end
            ST_BOOT, ST_READY: begin
                if (any_fault)                                      state_next = ST_FAULT;
                else if (!any_en)                                   state_next = ST_IDLE;
                else if (!chain_ok)                                 state_next = ST_RAMP;
                else if (state == ST_BOOT && boot_cnt == BOOT_LAST) state_next = ST_READY;
            end
            ST_FAULT: if (fault_clr_i && !any_en && !any_fault) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
        if (!ctrl_rst_n_i)                                 boot_cnt <= '0;
        else if (state == ST_BOOT && state_next == ST_BOOT) boot_cnt <= boot_cnt + BW'(1);
        else                                               boot_cnt <= '0;
    end

    always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
        if (!ctrl_rst_n_i) begin
            flag_to   <= '0;
            flag_drop <= '0;
        end else if (state == ST_FAULT && state_next == ST_IDLE) begin
            flag_to   <= '0;
            flag_drop <= '0;
        end else if (state_next == ST_FAULT) begin
            flag_to   <= flag_to | to_vec;
            flag_drop <= flag_drop | drop_vec;
        end
    end

`ifdef CAM_PWR_FAULT_IRQ_EN
    always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
        if (!ctrl_rst_n_i) fault_irq_o <= 1'b0;
        else               fault_irq_o <= (state != ST_FAULT) && (state_next == ST_FAULT);
    end
`endif

    always_comb begin
        cam_ready_o     = (state == ST_READY);
        pwr_fault_o     = (state == ST_FAULT);
        fault_timeout_o = flag_to;
        fault_drop_o    = flag_drop;
        state_o         = state;
    end

endmodule

// File: tb/tb_camera_power_supervisor.sv
// Bench for camera_power_supervisor: directed scenarios plus random stimulus,
// every cycle compared against a rule-level behavioural model.
module tb_camera_power_supervisor;

    localparam logic [31:0] PG_TIMEOUT    = 32'd16;
    localparam logic [31:0] GLITCH_CYCLES = 32'd4;
    localparam logic [31:0] BOOT_DELAY    = 32'd32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] en = '0;
    logic [2:0] pg = '0;
    logic       xclr = 1'b0;
    logic       inck_en = 1'b0;
    logic       fault_clr = 1'b0;
    logic       cam_ready;
    logic       pwr_fault;
    logic [2:0] fault_timeout;
    logic [2:0] fault_drop;
    logic [2:0] state;
`ifdef CAM_PWR_FAULT_IRQ_EN
    logic       fault_irq;
`endif

    int checks = 0;
    int errors = 0;

    camera_power_supervisor #(
        .PG_TIMEOUT   (PG_TIMEOUT),
        .GLITCH_CYCLES(GLITCH_CYCLES),
        .BOOT_DELAY   (BOOT_DELAY)
    ) dut (
        .ctrl_clk_i     (clk),
        .ctrl_rst_n_i   (rst_n),
        .reg_1v2_en_i   (en[0]),
        .reg_1v8_en_i   (en[1]),
        .reg_3v3_en_i   (en[2]),
        .xclr_i         (xclr),
        .inck_en_i      (inck_en),
        .pg_1v2_i       (pg[0]),
        .pg_1v8_i       (pg[1]),
        .pg_3v3_i       (pg[2]),
        .fault_clr_i    (fault_clr),
        .cam_ready_o    (cam_ready),
        .pwr_fault_o    (pwr_fault),
        .fault_timeout_o(fault_timeout),
        .fault_drop_o   (fault_drop),
        .state_o        (state)
`ifdef CAM_PWR_FAULT_IRQ_EN
        ,
        .fault_irq_o    (fault_irq)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Rails: on / good / timed-out / dropped flags with plain integer timers.
    logic [2:0] m_on = '0, m_good = '0, m_to = '0, m_drop = '0;
    logic [2:0] m_s1 = '0, m_s2 = '0, m_fto = '0, m_fdr = '0;
    int         m_age [3] = '{0, 0, 0};
    int         m_low [3] = '{0, 0, 0};
    int         m_mode = 0;   // 0 idle, 1 ramp, 2 boot, 3 ready, 4 fault
    int         m_boot = 0;
    logic       m_irq = 1'b0;

    task model_reset();
        m_on = '0; m_good = '0; m_to = '0; m_drop = '0;
        m_s1 = '0; m_s2 = '0; m_fto = '0; m_fdr = '0;
        for (int r = 0; r < 3; r++) begin m_age[r] = 0; m_low[r] = 0; end
        m_mode = 0; m_boot = 0; m_irq = 1'b0;
    endtask

    task model_step();
        logic [2:0] tov, drv;
        logic fault_any, any_en, chain_ok, good_all;
        tov = m_to;
        drv = m_drop;
        fault_any = |(tov | drv);
        any_en    = |en;
        chain_ok  = (&en) && xclr && inck_en;
        good_all  = &(m_good & ~m_drop & ~m_to);
        m_irq = 1'b0;
        if (m_mode == 0) begin
            if (any_en) m_mode = 1;
        end else if (m_mode == 4) begin
            m_fto |= tov;
            m_fdr |= drv;
            if (fault_clr && !any_en && !fault_any) begin
                m_mode = 0; m_fto = '0; m_fdr = '0;
            end
        end else if (fault_any) begin
            m_mode = 4; m_fto |= tov; m_fdr |= drv; m_irq = 1'b1;
        end else if (!any_en) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (good_all && xclr && inck_en) begin m_mode = 2; m_boot = 0; end
        end else if (!chain_ok) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            m_boot++;
            if (m_boot == int'(BOOT_DELAY)) m_mode = 3;
        end
        for (int r = 0; r < 3; r++) begin
            if (!en[r]) begin
                m_on[r] = 0; m_good[r] = 0; m_to[r] = 0; m_drop[r] = 0;
                m_age[r] = 0; m_low[r] = 0;
            end else if (!m_on[r]) begin
                m_on[r] = 1; m_age[r] = 0;
            end else if (!(m_to[r] || m_drop[r])) begin
                if (!m_good[r]) begin
                    if (m_s2[r] && m_age[r] < int'(PG_TIMEOUT)) begin
                        m_good[r] = 1; m_low[r] = 0;
                    end else if (m_age[r] >= int'(PG_TIMEOUT)) begin
                        m_to[r] = 1;
                    end else begin
                        m_age[r]++;
                    end
                end else if (m_s2[r]) begin
                    m_low[r] = 0;
                end else begin
                    m_low[r]++;
                    if (m_low[r] >= int'(GLITCH_CYCLES)) m_drop[r] = 1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = pg;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("state", 32'(state), 32'(m_mode));
        chk("cam_ready", 32'(cam_ready), 32'(m_mode == 3));
        chk("pwr_fault", 32'(pwr_fault), 32'(m_mode == 4));
        chk("fault_timeout", 32'(fault_timeout), 32'(m_fto));
        chk("fault_drop", 32'(fault_drop), 32'(m_fdr));
`ifdef CAM_PWR_FAULT_IRQ_EN
        chk("fault_irq", 32'(fault_irq), 32'(m_irq));
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic wait_state(input logic [2:0] s, input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (state !== s && n < bound);
        checks++;
        if (state !== s) begin
            errors++;
            $display("FAIL wait_state: state %0d after %0d cycles, required %0d", state, n, s);
        end
    endtask

    task automatic idle_inputs();
        en = '0; pg = '0; xclr = 0; inck_en = 0; fault_clr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic bring_up();
        int n;
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            en[r] = 1;
            repeat (5) @(negedge clk);
            pg[r] = 1;
        end
        xclr = 1; inck_en = 1;
        wait_state(3'd2, 60, n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!cam_ready && n < 100);
        chk("boot_to_ready_cycles", 32'(n), 32'd32);
    endtask

    task automatic clear_fault();
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        fault_clr = 1;
        @(posedge clk); #1;
        chk("clear_state", 32'(state), 32'd0);
        chk("clear_timeout", 32'(fault_timeout), 32'd0);
        chk("clear_drop", 32'(fault_drop), 32'd0);
        @(negedge clk);
        fault_clr = 0;
    endtask

    // ---------------- stimulus ----------------
    int lag [3] = '{0, 0, 0};
    int burst [3] = '{0, 0, 0};

    initial begin
        int n;
        rst_n = 0;
        do_reset();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_ready", 32'(cam_ready), 32'd0);
        chk("reset_pwr_fault", 32'(pwr_fault), 32'd0);

        // nominal bring-up, then glitch filter in READY
        bring_up();
        chk("nominal_timeout_flags", 32'(fault_timeout), 32'd0);
        chk("nominal_drop_flags", 32'(fault_drop), 32'd0);
        @(negedge clk); pg[2] = 0;
        repeat (3) @(negedge clk); pg[2] = 1;
        repeat (8) @(negedge clk);
        chk("short_glitch_ready", 32'(state), 32'd3);
        pg[2] = 0;
        repeat (4) @(negedge clk); pg[2] = 1;
        wait_state(3'd4, 20, n);
        chk("drop_flags", 32'(fault_drop), 32'b100);
        chk("drop_timeout_flags", 32'(fault_timeout), 32'd0);
        chk("drop_ready", 32'(cam_ready), 32'd0);
        chk("drop_pwr_fault", 32'(pwr_fault), 32'd1);

        // clear ignored while enables high, accepted once they are low
        @(negedge clk); fault_clr = 1;
        @(negedge clk); fault_clr = 0;
        chk("clr_ignored_state", 32'(state), 32'd4);
        chk("clr_ignored_drop", 32'(fault_drop), 32'b100);
        clear_fault();

        // 1v8 ramp timeout
        @(negedge clk); en[0] = 1;
        repeat (5) @(negedge clk); pg[0] = 1;
        repeat (5) @(negedge clk); en[1] = 1;
        wait_state(3'd4, 40, n);
        chk("timeout_latency", 32'(n), 32'd19);
        chk("timeout_flags", 32'(fault_timeout), 32'b010);
        chk("timeout_pwr_fault", 32'(pwr_fault), 32'd1);
        chk("timeout_ready", 32'(cam_ready), 32'd0);
`ifdef CAM_PWR_FAULT_IRQ_EN
        chk("irq_entry", 32'(fault_irq), 32'd1);
        @(posedge clk); #1;
        chk("irq_one_cycle", 32'(fault_irq), 32'd0);
`endif
        clear_fault();

        // teardown via XCLR, then async reset mid-BOOT
        bring_up();
        @(negedge clk); xclr = 0;
        @(posedge clk); #1;
        chk("teardown_state", 32'(state), 32'd1);
        chk("teardown_ready", 32'(cam_ready), 32'd0);
        chk("teardown_pwr_fault", 32'(pwr_fault), 32'd0);
        @(negedge clk); xclr = 1;
        wait_state(3'd2, 10, n);
        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_ready", 32'(cam_ready), 32'd0);
        chk("async_rst_flags", 32'({fault_timeout, fault_drop, pwr_fault}), 32'd0);
        @(negedge clk); idle_inputs();
        @(negedge clk); rst_n = 1;

        // randomized operation
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1500) rst_n = 0;
            else if (i == 1502) rst_n = 1;
            for (int r = 0; r < 3; r++) begin
                if (!en[r] && $urandom_range(0, 59) == 0) begin
                    en[r] = 1; lag[r] = $urandom_range(0, 20);
                end else if (en[r] && $urandom_range(0, 399) == 0) begin
                    en[r] = 0;
                end
                if (!en[r]) begin
                    pg[r] = 0;
                end else if (lag[r] > 0) begin
                    lag[r]--; pg[r] = 0;
                end else if (burst[r] > 0) begin
                    burst[r]--; pg[r] = 0;
                end else begin
                    pg[r] = 1;
                    if ($urandom_range(0, 99) < 2) burst[r] = $urandom_range(1, 6);
                end
            end
            if (m_mode == 4 && $urandom_range(0, 15) == 0) begin en = '0; pg = '0; end
            xclr      = xclr ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 19) == 0);
            inck_en   = inck_en ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 19) == 0);
            fault_clr = ($urandom_range(0, 29) == 0);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
